// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame engine: FSM state
// encodings, parity-type codes, payload width bounds and the parity helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

    // Parity bit for a payload zero-extended to the widest legal width;
    // zero padding does not change the XOR reduction.
    function automatic logic frame_parity(input logic [DATA_WIDTH_MAX-1:0] data,
                                          input logic                      par_typ);
        return (^data) ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_frame_engine_if.sv
// Data-source side of the frame engine: payload, valid/ack handshake and
// the per-frame configuration that is latched on acceptance.
interface uart_tx_frame_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic                  data_ack;

    modport master (
        output p_data, data_valid, par_en, par_typ, stop2,
        input  data_ack
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, stop2,
        output data_ack
    );
endinterface

// File: rtl/uart_tx_shifter.sv
// Payload shift register and bit counter for the UART transmitter.
// bit_out is the bit to put on the line next; last_bit is set once every
// payload bit has been handed out.
module uart_tx_shifter
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  bit_out,
    output logic                  last_bit
);
    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shreg_d, shreg_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;

    // Next-state for the shift register and counter: load wins over shift.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = load_data;
            cnt_d   = '0;
        end else if (shift) begin
            shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the datapath register is cleared too, so an aborted frame
            // leaves no stale payload behind.
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together.
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_out  = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[DATA_WIDTH-1];
    assign last_bit = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: accepts a payload on a baud tick, then sends
// start bit, payload, optional parity and one or two stop bits. Back-to-back
// frames are accepted on the final stop bit with no idle gap.
module uart_tx_frame_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    uart_tx_frame_engine_if.slave  bus,
    output logic                   tx_out,
    output logic                   busy
);
    // An out-of-range width elaborates a module that does not exist,
    // stopping the build instead of producing a silently wrong frame.
    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_illegal_width
        uart_tx_illegal_data_width u_illegal ();
    end

    tx_state_e  state_d, state_q;
    logic       tx_d, tx_q;
    logic       busy_d, busy_q;
    logic       ack_d, ack_q;
    logic       parity_d, parity_q;
    logic       par_en_d, par_en_q;
    logic       stop2_d, stop2_q;
    logic [1:0] stop_cnt_d, stop_cnt_q;

    logic       load, shift;
    logic       bit_out, last_bit;
    logic       final_stop, accept;

    uart_tx_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (bus.p_data),
        .bit_out   (bit_out),
        .last_bit  (last_bit)
    );

    assign final_stop = !stop2_q || (stop_cnt_q == 2'd2);
    assign accept     = tick && bus.data_valid &&
                        ((state_q == ST_IDLE) || (state_q == ST_STOP && final_stop));

    // Frame FSM next-state and registered-output decode; acceptance overrides
    // the IDLE/STOP decisions because it starts a fresh frame.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        parity_d   = parity_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        load       = 1'b0;
        shift      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_d    = bit_out;
                    shift   = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (!last_bit) begin
                        tx_d  = bit_out;
                        shift = 1'b1;
                    end else if (par_en_q) begin
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 2'd1;
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 2'd1;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (!final_stop) begin
                        stop_cnt_d = 2'd2;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                // Unreachable encodings recover at once, tick or not.
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            load       = 1'b1;
            parity_d   = frame_parity(DATA_WIDTH_MAX'(bus.p_data), bus.par_typ);
            par_en_d   = bus.par_en;
            stop2_d    = bus.stop2;
            stop_cnt_d = 2'd0;
            ack_d      = 1'b1;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            state_d    = ST_START;
        end
    end

    // FSM and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            parity_q   <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            parity_q   <= parity_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    assign tx_out       = tx_q;
    assign busy         = busy_q;
    assign bus.data_ack = ack_q;

endmodule

// File: doc/uart_tx_frame_engine.md
Name: uart_tx_frame_engine

Overview:
Parametrised UART transmit frame engine. It merges the TX control FSM, serializer, parity generator and output mux into one block. It also adds:
- configurable data width and bit order
- even/odd parity
- one or two stop bits
- baud-tick pacing
- a data-accept handshake

It sits between the TX data source (register file or FIFO) and the TX pin. It replaces the separate FSM/serializer/parity/mux arrangement.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
LSB_FIRST, 1, 1 = payload sent LSB first; 0 = MSB first.

Ports:
clk        input   1           system clock
rst        input   1           synchronous active-low reset
tick       input   1           baud enable, one-cycle pulse per bit period
p_data     input   DATA_WIDTH  parallel payload
data_valid input   1           payload available
par_en     input   1           1 = parity bit inserted
par_typ    input   1           0 = even, 1 = odd
stop2      input   1           1 = two stop bits, 0 = one
data_ack   output  1           one-cycle pulse: p_data captured this cycle
tx_out     output  1           serial line, idle high
busy       output  1           frame in progress

Behaviour:
- Reset: one clock; reset is synchronous and active-low. On a clk edge with rst=0:
  - state = IDLE; tx_out = 1, busy = 0, data_ack = 0
  - shift register, bit counter and stop counter cleared
  - reset mid-frame aborts the frame; the line returns high on the next cycle.
- All outputs are registered. tx_out and state change only on cycles with tick=1.
- Every frame bit therefore lasts exactly one tick period.
- Acceptance occurs on a cycle with tick=1 and data_valid=1, in either of:
  - state IDLE
  - state STOP on the final stop bit
- On acceptance:
  - p_data is captured into the shift register
  - par_en, par_typ and stop2 are latched
  - parity = XOR(p_data) XOR par_typ
  - data_ack = 1 for that cycle only
  - next cycle: state START, tx_out = 0, busy = 1
- Config and p_data changes after acceptance have no effect on the current frame.
- data_valid without tick causes no acceptance and no ack.
- States and transitions (each evaluated only when tick=1):
  - IDLE -> START on acceptance; otherwise remain, tx_out = 1.
  - START -> DATA: tx_out = first payload bit (bit 0 if LSB_FIRST, else bit DATA_WIDTH-1); bit counter = 1.
  - DATA, counter < DATA_WIDTH: shift and output the next bit; counter++.
  - DATA, counter = DATA_WIDTH -> PARITY with tx_out = parity, if latched par_en = 1.
  - DATA, counter = DATA_WIDTH -> STOP with tx_out = 1, stop counter = 1, if par_en = 0.
  - PARITY -> STOP: tx_out = 1, stop counter = 1.
  - STOP, latched stop2 = 1 and stop counter = 1: remain in STOP; stop counter = 2.
  - STOP, final stop bit with acceptance -> START, tx_out = 0. This gives back-to-back frames with no idle gap; busy stays 1.
  - STOP, final stop bit without acceptance -> IDLE: tx_out = 1, busy = 0.
- Illegal state encodings go to IDLE on the next clk with tx_out = 1 and busy = 0, independent of tick.
- The bit counter is $clog2(DATA_WIDTH+1) bits wide and never wraps within a frame.
- Frame length in ticks = 1 + DATA_WIDTH + par_en + (1 + stop2).

Decomposition:
- Package uart_tx_pkg holds:
  - state encodings (IDLE, START, DATA, PARITY, STOP; 3-bit)
  - PAR_EVEN = 0, PAR_ODD = 1
  - DATA_WIDTH legality bounds
- One sub-module: uart_tx_shifter. It contains the DATA_WIDTH shift register, load/shift controls, the LSB_FIRST bit select and the bit counter, and exposes a last_bit flag.
- FSM, parity and tx_out register remain in the top module.

Test Plan:
- DATA_WIDTH=8, tick every 4 clk, p_data=0xA5, par_en=0, stop2=0 -> data_ack pulses once; tx_out = 0,1,0,1,0,0,1,0,1,1 (4 clk each); busy high for 40 clk, then 0.
- Same with par_en=1: par_typ=0 -> parity bit 0; par_typ=1 -> parity bit 1; frame = 11 ticks.
- data_valid held high with 0x0F then 0xF0, stop2=1 -> two stop ticks, then start bit immediately; no idle tick; two data_ack pulses; busy never drops between frames.
- Toggle par_en, par_typ and p_data mid-frame -> serial stream matches the values latched at acceptance.
- Assert rst=0 during DATA bit 4 -> next cycle tx_out = 1, busy = 0, state IDLE; a new data_valid after release sends a full clean frame.
- DATA_WIDTH=7, LSB_FIRST=0, p_data=7'h41 -> data bits 1,0,0,0,0,0,1; frame = 9 ticks with no parity and one stop bit.
